cache_set_ctrl: RTL and testbench
=================================

Name: cache_set_ctrl

Overview:
- Write-back, write-allocate cache controller that sequences the cache `set` block (compare/access × read/write operations) between one CPU requester and main memory.
- Hits are served by a single compare operation on the set.
- On a miss, a dirty victim line (4 words) is written back to memory, the line is refilled from memory, and the compare is retried.
- Sits between the CPU port and the `set` array/memory bus.

Parameters:
- TAG_W, 5, tag width; matches the set tag port.
- IDX_W, 3, set index width; index is presented to external set-select logic.
- DATA_W, 16, word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  TAG_W+IDX_W+2  {tag, index, word}.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack is high.
- cpu_ack  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- set_enable, set_cmp, set_write  out  1 each  set operation controls.
- set_word  out  2  word select.
- set_tag  out  TAG_W  tag to set.
- set_index  out  IDX_W  index to set-select logic.
- set_data_in  out  DATA_W  write data to set.
- set_valid_in, set_dirty_in  out  1 each  line state for access-writes.
- set_hit, set_dirty, set_valid, set_ack  in  1 each  set responses.
- set_tag_out  in  TAG_W  victim tag.
- set_data_out  in  DATA_W  set read data.
- mem_req, mem_we  out  1 each  memory request and direction.
- mem_addr  out  TAG_W+IDX_W+2  word address.
- mem_wdata  out  DATA_W  write data to memory.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle memory completion.

Behaviour:
- Clocking/reset:
  - One clock; reset is synchronous and active-high.
  - Reset forces state IDLE; all outputs to 0; word counter to 0.
  - Reset mid-operation abandons any set or memory transaction: set_enable and mem_req are 0 on the cycle after reset is sampled.
  - No partial state is preserved across reset.
- Registered outputs: every output is registered. The CPU fields are latched when a request is accepted in IDLE.
- Set handshake:
  - Operation fields are driven with set_enable=1 and held stable until set_ack is sampled high.
  - Set outputs are captured on that edge.
  - set_enable then drops for at least 1 cycle before the next operation.
- Memory handshake:
  - mem_req and fields are held until mem_ack.
  - mem_rdata is captured on mem_ack.
  - mem_req drops for at least 1 cycle between transactions.
- Set operation encoding:
  - cmp=1, write=0: compare-read.
  - cmp=1, write=1: compare-write; sets dirty on hit.
  - cmp=0, write=0: victim access-read; returns data, tag_out, valid, dirty.
  - cmp=0, write=1: access-write of word, tag, valid_in, dirty_in.
- State IDLE: when cpu_req=1, latch inputs and go to CMP.
- State CMP:
  - Compare op with cmp=1, write=cpu_we, word, tag and data from the latched request.
  - On ack with hit=1: cpu_ack=1 for one cycle, cpu_rdata=set_data_out (read); go to IDLE.
  - On ack with hit=0: go to VICT.
- State VICT:
  - Access-read of word 0.
  - On ack, latch victim tag, valid and dirty.
  - If valid&dirty: go to WB_MEM with cnt=0 and buffer = set_data_out.
  - Otherwise: go to FILL_MEM with cnt=0.
- State WB_MEM:
  - Memory write: mem_addr={victim_tag, idx, cnt}, mem_wdata=buffer.
  - On mem_ack with cnt=3: go to FILL_MEM, cnt=0.
  - On mem_ack otherwise: cnt+1, go to WB_RD.
- State WB_RD: access-read of word cnt; on ack, buffer = data; go to WB_MEM.
- State FILL_MEM: memory read {cpu_tag, idx, cnt}; on mem_ack, buffer = mem_rdata; go to FILL_SET.
- State FILL_SET:
  - Access-write of word cnt with tag=cpu_tag, valid_in=1, dirty_in=0.
  - On ack with cnt=3: go to CMP (retry, which must hit).
  - On ack otherwise: cnt+1, go to FILL_MEM.
- Counters and latency:
  - cnt is 2 bits; wraps 3→0 only on the state-exit paths above.
  - Hit latency from request to cpu_ack = 1 (accept) + set op cycles + 1.
  - cpu_req is ignored while busy.
- Unsupported response: set_ack or mem_ack arriving while no request is outstanding is ignored.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined, adds 16-bit outputs hit_count and miss_count:
  - Each saturates at 0xFFFF and is cleared by rst.
  - hit_count increments on a CMP hit of the first compare only.
  - miss_count increments on each CMP miss.
  - The retry compare after a refill does not count.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Bench models: set acks 1 cycle after seeing enable; memory acks 2 cycles after seeing req.
- Read hit: preload word 3 tag 5'b11101 = 16'h0F0F; read addr {11101, idx, 3} -> cpu_ack 3 cycles after req; cpu_rdata = 16'h0F0F; no mem_req.
- Write hit: write 16'hA5A5 to a resident word -> one compare-write with set_write=1, set_cmp=1; cpu_ack; a later read returns 16'hA5A5.
- Clean miss: victim valid=1, dirty=0 -> no mem writes; 4 mem reads of addresses {tag, idx, 0..3}; 4 access-writes with valid_in=1, dirty_in=0; retry hit; cpu_ack with the correct data.
- Dirty miss: victim tag 5'b00011 dirty -> 4 mem writes to {00011, idx, 0..3} carrying the victim data, then refill, then cpu_ack.
- Reset mid-operation: assert rst during WB_MEM -> next cycle busy=0, mem_req=0, set_enable=0, cpu_ack=0; a new request then proceeds normally.
- CACHE_STATS_EN build: 2 hits and 1 miss -> hit_count=2, miss_count=1.

Source files
------------

// File: rtl/cache_set_ctrl.sv
// Write-back, write-allocate controller sequencing one cache set array and a memory bus for one CPU.
// Latency: a hit returns cpu_ack 3 cycles after the request is sampled; misses add victim write-back and refill.
// Backpressure: cpu_req is held until cpu_ack; set and memory ops hold their fields until the matching ack.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request; cpu_addr = {tag, index, word}
//   cpu_rdata, cpu_ack, busy      CPU response; busy is high outside IDLE
//   set_*  (out)                  operation to the set: enable, cmp, write, word, tag, index, data, valid_in, dirty_in
//   set_*  (in)                   set response: hit, dirty, valid, ack, tag_out, data_out
//   mem_req/we/addr/wdata         memory request, word address
//   mem_rdata, mem_ack            memory response
//   hit_count, miss_count         saturating statistics, only when CACHE_STATS_EN is defined
//
// Build option: CACHE_STATS_EN adds the hit/miss statistics counters and ports.

module cache_set_ctrl #(
   parameter int TAG_W  = 5,
   parameter int IDX_W  = 3,
   parameter int DATA_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cpu_req,
   input  logic                      cpu_we,
   input  logic [TAG_W+IDX_W+1:0]    cpu_addr,
   input  logic [DATA_W-1:0]         cpu_wdata,
   output logic [DATA_W-1:0]         cpu_rdata,
   output logic                      cpu_ack,
   output logic                      busy,
   output logic                      set_enable,
   output logic                      set_cmp,
   output logic                      set_write,
   output logic [1:0]                set_word,
   output logic [TAG_W-1:0]          set_tag,
   output logic [IDX_W-1:0]          set_index,
   output logic [DATA_W-1:0]         set_data_in,
   output logic                      set_valid_in,
   output logic                      set_dirty_in,
   input  logic                      set_hit,
   input  logic                      set_dirty,
   input  logic                      set_valid,
   input  logic                      set_ack,
   input  logic [TAG_W-1:0]          set_tag_out,
   input  logic [DATA_W-1:0]         set_data_out,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [TAG_W+IDX_W+1:0]    mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_ack
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]               hit_count,
   output logic [15:0]               miss_count
`endif
);

   localparam int AW = TAG_W + IDX_W + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMP,
      S_VICT,
      S_WB_MEM,
      S_WB_RD,
      S_FILL_MEM,
      S_FILL_SET
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   buf_q, buf_d;
   logic [TAG_W-1:0]    vtag_q, vtag_d;
   logic                retry_q, retry_d;

   // latched CPU request
   logic                req_we_q, req_we_d;
   logic [TAG_W-1:0]    req_tag_q, req_tag_d;
   logic [IDX_W-1:0]    req_idx_q, req_idx_d;
   logic [1:0]          req_word_q, req_word_d;
   logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;

   // registered outputs
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic                cpu_ack_q, cpu_ack_d;
   logic                busy_q, busy_d;
   logic                set_enable_q, set_enable_d;
   logic                set_cmp_q, set_cmp_d;
   logic                set_write_q, set_write_d;
   logic [1:0]          set_word_q, set_word_d;
   logic [TAG_W-1:0]    set_tag_q, set_tag_d;
   logic [DATA_W-1:0]   set_data_in_q, set_data_in_d;
   logic                set_valid_in_q, set_valid_in_d;
   logic                set_dirty_in_q, set_dirty_in_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [AW-1:0]       mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

`ifdef CACHE_STATS_EN
   logic [15:0]         hit_cnt_q, hit_cnt_d;
   logic [15:0]         miss_cnt_q, miss_cnt_d;
`endif

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      buf_d          = buf_q;
      vtag_d         = vtag_q;
      retry_d        = retry_q;
      req_we_d       = req_we_q;
      req_tag_d      = req_tag_q;
      req_idx_d      = req_idx_q;
      req_word_d     = req_word_q;
      req_wdata_d    = req_wdata_q;
      cpu_rdata_d    = cpu_rdata_q;
      cpu_ack_d      = 1'b0;
      set_enable_d   = set_enable_q;
      set_cmp_d      = set_cmp_q;
      set_write_d    = set_write_q;
      set_word_d     = set_word_q;
      set_tag_d      = set_tag_q;
      set_data_in_d  = set_data_in_q;
      set_valid_in_d = set_valid_in_q;
      set_dirty_in_d = set_dirty_in_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
`ifdef CACHE_STATS_EN
      hit_cnt_d      = hit_cnt_q;
      miss_cnt_d     = miss_cnt_q;
`endif

      // Each op state raises its request on the first cycle it sees the
      // enable/req low, holds it, and drops it on the ack edge. That drop
      // guarantees at least one idle cycle before the next state raises.
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               req_we_d       = cpu_we;
               req_tag_d      = cpu_addr[AW-1 -: TAG_W];
               req_idx_d      = cpu_addr[IDX_W+1:2];
               req_word_d     = cpu_addr[1:0];
               req_wdata_d    = cpu_wdata;
               retry_d        = 1'b0;
               cnt_d          = 2'd0;
               // issue the compare straight away to save a cycle on hits
               set_enable_d   = 1'b1;
               set_cmp_d      = 1'b1;
               set_write_d    = cpu_we;
               set_word_d     = cpu_addr[1:0];
               set_tag_d      = cpu_addr[AW-1 -: TAG_W];
               set_data_in_d  = cpu_wdata;
               set_valid_in_d = 1'b0;
               set_dirty_in_d = 1'b0;
               state_d        = S_CMP;
            end
         end

         S_CMP: begin
            if (!set_enable_q) begin
               set_enable_d   = 1'b1;
               set_cmp_d      = 1'b1;
               set_write_d    = req_we_q;
               set_word_d     = req_word_q;
               set_tag_d      = req_tag_q;
               set_data_in_d  = req_wdata_q;
               set_valid_in_d = 1'b0;
               set_dirty_in_d = 1'b0;
            end else if (set_ack) begin
               set_enable_d = 1'b0;
               if (set_hit) begin
                  cpu_ack_d = 1'b1;
                  if (!req_we_q) begin
                     cpu_rdata_d = set_data_out;
                  end
                  state_d = S_IDLE;
`ifdef CACHE_STATS_EN
                  // the post-refill retry is a consequence of a counted miss
                  if (!retry_q && hit_cnt_q != 16'hFFFF) begin
                     hit_cnt_d = hit_cnt_q + 16'd1;
                  end
`endif
               end else begin
                  state_d = S_VICT;
`ifdef CACHE_STATS_EN
                  if (miss_cnt_q != 16'hFFFF) begin
                     miss_cnt_d = miss_cnt_q + 16'd1;
                  end
`endif
               end
            end
         end

         S_VICT: begin
            if (!set_enable_q) begin
               set_enable_d = 1'b1;
               set_cmp_d    = 1'b0;
               set_write_d  = 1'b0;
               set_word_d   = 2'd0;
            end else if (set_ack) begin
               set_enable_d = 1'b0;
               vtag_d       = set_tag_out;
               cnt_d        = 2'd0;
               if (set_valid && set_dirty) begin
                  buf_d   = set_data_out;
                  state_d = S_WB_MEM;
               end else begin
                  state_d = S_FILL_MEM;
               end
            end
         end

         S_WB_MEM: begin
            if (!mem_req_q) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {vtag_q, req_idx_q, cnt_q};
               mem_wdata_d = buf_q;
            end else if (mem_ack) begin
               mem_req_d = 1'b0;
               if (cnt_q == 2'd3) begin
                  cnt_d   = 2'd0;
                  state_d = S_FILL_MEM;
               end else begin
                  cnt_d   = cnt_q + 2'd1;
                  state_d = S_WB_RD;
               end
            end
         end

         S_WB_RD: begin
            if (!set_enable_q) begin
               set_enable_d = 1'b1;
               set_cmp_d    = 1'b0;
               set_write_d  = 1'b0;
               set_word_d   = cnt_q;
            end else if (set_ack) begin
               set_enable_d = 1'b0;
               buf_d        = set_data_out;
               state_d      = S_WB_MEM;
            end
         end

         S_FILL_MEM: begin
            if (!mem_req_q) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {req_tag_q, req_idx_q, cnt_q};
            end else if (mem_ack) begin
               mem_req_d = 1'b0;
               buf_d     = mem_rdata;
               state_d   = S_FILL_SET;
            end
         end

         S_FILL_SET: begin
            if (!set_enable_q) begin
               set_enable_d   = 1'b1;
               set_cmp_d      = 1'b0;
               set_write_d    = 1'b1;
               set_word_d     = cnt_q;
               set_tag_d      = req_tag_q;
               set_data_in_d  = buf_q;
               set_valid_in_d = 1'b1;
               set_dirty_in_d = 1'b0;
            end else if (set_ack) begin
               set_enable_d = 1'b0;
               if (cnt_q == 2'd3) begin
                  cnt_d   = 2'd0;
                  retry_d = 1'b1;
                  state_d = S_CMP;
               end else begin
                  cnt_d   = cnt_q + 2'd1;
                  state_d = S_FILL_MEM;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         buf_q          <= '0;
         vtag_q         <= '0;
         retry_q        <= 1'b0;
         req_we_q       <= 1'b0;
         req_tag_q      <= '0;
         req_idx_q      <= '0;
         req_word_q     <= '0;
         req_wdata_q    <= '0;
         cpu_rdata_q    <= '0;
         cpu_ack_q      <= 1'b0;
         busy_q         <= 1'b0;
         set_enable_q   <= 1'b0;
         set_cmp_q      <= 1'b0;
         set_write_q    <= 1'b0;
         set_word_q     <= '0;
         set_tag_q      <= '0;
         set_data_in_q  <= '0;
         set_valid_in_q <= 1'b0;
         set_dirty_in_q <= 1'b0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
`ifdef CACHE_STATS_EN
         hit_cnt_q      <= '0;
         miss_cnt_q     <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         buf_q          <= buf_d;
         vtag_q         <= vtag_d;
         retry_q        <= retry_d;
         req_we_q       <= req_we_d;
         req_tag_q      <= req_tag_d;
         req_idx_q      <= req_idx_d;
         req_word_q     <= req_word_d;
         req_wdata_q    <= req_wdata_d;
         cpu_rdata_q    <= cpu_rdata_d;
         cpu_ack_q      <= cpu_ack_d;
         busy_q         <= busy_d;
         set_enable_q   <= set_enable_d;
         set_cmp_q      <= set_cmp_d;
         set_write_q    <= set_write_d;
         set_word_q     <= set_word_d;
         set_tag_q      <= set_tag_d;
         set_data_in_q  <= set_data_in_d;
         set_valid_in_q <= set_valid_in_d;
         set_dirty_in_q <= set_dirty_in_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
`ifdef CACHE_STATS_EN
         hit_cnt_q      <= hit_cnt_d;
         miss_cnt_q     <= miss_cnt_d;
`endif
      end
   end

   assign cpu_rdata    = cpu_rdata_q;
   assign cpu_ack      = cpu_ack_q;
   assign busy         = busy_q;
   assign set_enable   = set_enable_q;
   assign set_cmp      = set_cmp_q;
   assign set_write    = set_write_q;
   assign set_word     = set_word_q;
   assign set_tag      = set_tag_q;
   assign set_index    = req_idx_q;
   assign set_data_in  = set_data_in_q;
   assign set_valid_in = set_valid_in_q;
   assign set_dirty_in = set_dirty_in_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
`ifdef CACHE_STATS_EN
   assign hit_count    = hit_cnt_q;
   assign miss_count   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed bench for cache_set_ctrl with a one-line-per-index set model and a word memory model.
// Set model acks one cycle after it sees set_enable; memory acks a couple of cycles after mem_req.
// Set and memory contents are re-preloaded on every reset.

module tb_cache_set_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [9:0]  cpu_addr;
   logic [15:0] cpu_wdata, cpu_rdata;
   logic        cpu_ack, busy;
   logic        set_enable, set_cmp, set_write;
   logic [1:0]  set_word;
   logic [4:0]  set_tag, set_tag_out;
   logic [2:0]  set_index;
   logic [15:0] set_data_in, set_data_out;
   logic        set_valid_in, set_dirty_in;
   logic        set_hit, set_dirty, set_valid, set_ack;
   logic        mem_req, mem_we, mem_ack;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   cache_set_ctrl #(.TAG_W(5), .IDX_W(3), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .busy(busy),
      .set_enable(set_enable), .set_cmp(set_cmp), .set_write(set_write),
      .set_word(set_word), .set_tag(set_tag), .set_index(set_index),
      .set_data_in(set_data_in), .set_valid_in(set_valid_in), .set_dirty_in(set_dirty_in),
      .set_hit(set_hit), .set_dirty(set_dirty), .set_valid(set_valid), .set_ack(set_ack),
      .set_tag_out(set_tag_out), .set_data_out(set_data_out),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   // ---------------- set / memory models ----------------
   logic [4:0]  m_tag [8];
   logic        m_val [8];
   logic        m_dty [8];
   logic [15:0] m_dat [8][4];
   logic [15:0] mem   [1024];
   int          mcnt;
   int          si, sw;
   logic        shit;

   // traffic logs, written only by the model process
   int          wr_n, rd_n, aw_n, aw_bad, cw_n;
   logic [9:0]  wr_addr_log [64];
   logic [15:0] wr_data_log [64];
   logic [9:0]  rd_addr_log [64];

   initial begin
      wr_n = 0; rd_n = 0; aw_n = 0; aw_bad = 0; cw_n = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         set_ack <= 1'b0; set_hit <= 1'b0; set_dirty <= 1'b0; set_valid <= 1'b0;
         set_tag_out <= '0; set_data_out <= '0;
         mem_ack <= 1'b0; mem_rdata <= '0; mcnt = 0;
         for (int i = 0; i < 8; i++) begin
            m_tag[i] = '0; m_val[i] = 1'b0; m_dty[i] = 1'b0;
            for (int w = 0; w < 4; w++) m_dat[i][w] = '0;
         end
         m_tag[2] = 5'b11101; m_val[2] = 1'b1; m_dty[2] = 1'b0;
         m_dat[2][0] = 16'h2000; m_dat[2][1] = 16'h2001; m_dat[2][2] = 16'h2002; m_dat[2][3] = 16'h0F0F;
         m_tag[5] = 5'b00011; m_val[5] = 1'b1; m_dty[5] = 1'b1;
         for (int w = 0; w < 4; w++) m_dat[5][w] = 16'hD000 + 16'(w);
         m_tag[6] = 5'b01010; m_val[6] = 1'b1; m_dty[6] = 1'b0;
         for (int w = 0; w < 4; w++) m_dat[6][w] = 16'h6000 + 16'(w);
         for (int a = 0; a < 1024; a++) mem[a] = 16'h4000 | 16'(a);
      end else begin
         if (set_enable && !set_ack) begin
            si = int'(set_index); sw = int'(set_word);
            set_ack <= 1'b1;
            if (set_cmp) begin
               shit = m_val[si] && (m_tag[si] == set_tag);
               set_hit <= shit; set_data_out <= m_dat[si][sw];
               set_valid <= m_val[si]; set_dirty <= m_dty[si]; set_tag_out <= m_tag[si];
               if (set_write) begin
                  cw_n++;
                  if (shit) begin m_dat[si][sw] = set_data_in; m_dty[si] = 1'b1; end
               end
            end else if (!set_write) begin
               set_hit <= 1'b0; set_data_out <= m_dat[si][sw];
               set_valid <= m_val[si]; set_dirty <= m_dty[si]; set_tag_out <= m_tag[si];
            end else begin
               aw_n++;
               if (!(set_valid_in && !set_dirty_in)) aw_bad++;
               m_dat[si][sw] = set_data_in; m_tag[si] = set_tag;
               m_val[si] = set_valid_in; m_dty[si] = set_dirty_in;
            end
         end else begin
            set_ack <= 1'b0;
         end

         if (mem_req && !mem_ack) begin
            if (mcnt == 2) begin
               mcnt = 0;
               mem_ack <= 1'b1;
               if (mem_we) begin
                  mem[mem_addr] = mem_wdata;
                  wr_addr_log[wr_n % 64] = mem_addr; wr_data_log[wr_n % 64] = mem_wdata; wr_n++;
               end else begin
                  mem_rdata <= mem[mem_addr];
                  rd_addr_log[rd_n % 64] = mem_addr; rd_n++;
               end
            end else begin
               mcnt++;
            end
         end else begin
            mem_ack <= 1'b0; mcnt = 0;
         end
      end
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [9:0] addr, input logic [15:0] wd,
                         output logic [15:0] rd, output int cyc);
      logic done;
      done = 1'b0; rd = '0; cyc = 0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      for (int k = 0; k < 400 && !done; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (cpu_ack) begin rd = cpu_rdata; done = 1'b1; end
      end
      cpu_req = 1'b0;
      chk("ack_seen", {31'd0, done}, 32'd1);
   endtask

   logic [15:0] rd;
   int          cyc, wb, rb, awb, cwb;
   logic        seen;

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
      chk("rst_set_en", {31'd0, set_enable}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // read hit
      wb = wr_n; rb = rd_n;
      do_req(1'b0, {5'b11101, 3'd2, 2'd3}, 16'h0, rd, cyc);
      chk("rdhit_lat", cyc, 3);
      chk("rdhit_data", {16'd0, rd}, 32'h0F0F);
      chk("rdhit_nomem", (wr_n - wb) + (rd_n - rb), 0);

      // write hit then readback
      wb = wr_n; rb = rd_n; cwb = cw_n;
      do_req(1'b1, {5'b11101, 3'd2, 2'd1}, 16'hA5A5, rd, cyc);
      chk("wrhit_lat", cyc, 3);
      chk("wrhit_cmpwr", cw_n - cwb, 1);
      chk("wrhit_nomem", (wr_n - wb) + (rd_n - rb), 0);
      do_req(1'b0, {5'b11101, 3'd2, 2'd1}, 16'h0, rd, cyc);
      chk("wrhit_readback", {16'd0, rd}, 32'hA5A5);

      // clean miss: victim idx6 tag 01010 clean
      wb = wr_n; rb = rd_n; awb = aw_n;
      do_req(1'b0, {5'b10001, 3'd6, 2'd2}, 16'h0, rd, cyc);
      chk("clean_nowr", wr_n - wb, 0);
      chk("clean_rd_n", rd_n - rb, 4);
      for (int k = 0; k < 4; k++)
         chk("clean_rd_addr", {22'd0, rd_addr_log[(rb + k) % 64]}, {22'd0, 5'b10001, 3'd6, 2'(k)});
      chk("clean_aw_n", aw_n - awb, 4);
      chk("clean_data", {16'd0, rd}, 32'h423A);

      // dirty miss: victim idx5 tag 00011 dirty, write-allocate
      wb = wr_n; rb = rd_n;
      do_req(1'b1, {5'b00111, 3'd5, 2'd0}, 16'h1234, rd, cyc);
      chk("dirty_wr_n", wr_n - wb, 4);
      for (int k = 0; k < 4; k++) begin
         chk("dirty_wr_addr", {22'd0, wr_addr_log[(wb + k) % 64]}, {22'd0, 5'b00011, 3'd5, 2'(k)});
         chk("dirty_wr_data", {16'd0, wr_data_log[(wb + k) % 64]}, 32'hD000 + k);
      end
      chk("dirty_rd_n", rd_n - rb, 4);
      do_req(1'b0, {5'b00111, 3'd5, 2'd0}, 16'h0, rd, cyc);
      chk("dirty_rb_w0", {16'd0, rd}, 32'h1234);
      chk("dirty_rb_lat", cyc, 3);
      do_req(1'b0, {5'b00111, 3'd5, 2'd1}, 16'h0, rd, cyc);
      chk("dirty_rb_w1", {16'd0, rd}, 32'h40F5);
      chk("aw_flags", aw_bad, 0);

      // reset during write-back (idx2 is dirty after the write hit)
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {5'b00000, 3'd2, 2'd0};
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(posedge clk); #1;
         if (mem_req && mem_we) seen = 1'b1;
      end
      chk("rst_reach_wb", {31'd0, seen}, 32'd1);
      @(negedge clk); rst = 1'b1; cpu_req = 1'b0;
      @(posedge clk); #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("midrst_set_en", {31'd0, set_enable}, 32'd0);
      chk("midrst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
`ifdef CACHE_STATS_EN
      chk("midrst_hits", {16'd0, hit_count}, 32'd0);
      chk("midrst_miss", {16'd0, miss_count}, 32'd0);
`endif
      @(negedge clk); rst = 1'b0;

      do_req(1'b0, {5'b11101, 3'd2, 2'd3}, 16'h0, rd, cyc);
      chk("post_rst_lat", cyc, 3);
      chk("post_rst_data", {16'd0, rd}, 32'h0F0F);
      do_req(1'b0, {5'b11101, 3'd2, 2'd0}, 16'h0, rd, cyc);
      chk("post_rst_w0", {16'd0, rd}, 32'h2000);
      wb = wr_n;
      do_req(1'b0, {5'b00000, 3'd6, 2'd0}, 16'h0, rd, cyc);
      chk("miss2_data", {16'd0, rd}, 32'h4018);
      chk("miss2_nowr", wr_n - wb, 0);
`ifdef CACHE_STATS_EN
      chk("stat_hits", {16'd0, hit_count}, 32'd2);
      chk("stat_miss", {16'd0, miss_count}, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
